// File: rtl/instr_fetch.sv
// Instruction-fetch initiator: drives a 1-cycle-latency program memory, tracks the
// in-flight read, and delivers {instr, pc} to decode through a 2-entry buffer.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif

module instr_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_AW     = `MEM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = `MEM_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_v_q, inflight_v_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [DATA_WIDTH-1:0] fifo_instr_q [2];
  logic [DATA_WIDTH-1:0] fifo_instr_d [2];
  logic [ADDR_WIDTH-1:0] fifo_pc_q [2];
  logic [ADDR_WIDTH-1:0] fifo_pc_d [2];
  logic [1:0]            count_q, count_d;
  logic                  misaligned_q, misaligned_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign mem_addr   = fetch_pc_q[MEM_AW+1:2];
  assign out_valid  = (count_q != 2'd0);
  assign out_instr  = fifo_instr_q[0];
  assign out_pc     = fifo_pc_q[0];
  assign misaligned = misaligned_q;

  // Slots the buffer will need once the pending read lands, after this cycle's pop.
  assign pop       = out_valid & out_ready;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_v_q} - {2'b00, pop};
  assign issue     = fetch_en & ~redirect_valid & (occupancy <= 3'd1);
  assign push      = inflight_v_q & ~redirect_valid;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    fetch_pc_d    = fetch_pc_q;
    inflight_v_d  = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    count_d       = count_q;
    misaligned_d  = redirect_valid & (|redirect_pc[1:0]);

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      count_d    = 2'd0;
    end else begin
      if (issue) begin
        inflight_v_d  = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
      end

      unique case ({push, pop})
        2'b01: begin
          fifo_instr_d[0] = fifo_instr_q[1];
          fifo_pc_d[0]    = fifo_pc_q[1];
          count_d         = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            fifo_instr_d[0] = mem_rdata;
            fifo_pc_d[0]    = inflight_pc_q;
          end else begin
            fifo_instr_d[1] = mem_rdata;
            fifo_pc_d[1]    = inflight_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          // Head leaves while the new word enters behind whatever remains.
          if (count_q == 2'd1) begin
            fifo_instr_d[0] = mem_rdata;
            fifo_pc_d[0]    = inflight_pc_q;
          end else begin
            fifo_instr_d[0] = fifo_instr_q[1];
            fifo_pc_d[0]    = fifo_pc_q[1];
            fifo_instr_d[1] = mem_rdata;
            fifo_pc_d[1]    = inflight_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
      // NOTE: buffer storage is reset too, since its head drives out_instr/out_pc directly.
      fifo_instr_q  <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
      count_q       <= 2'd0;
      misaligned_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
      count_q       <= count_d;
      misaligned_q  <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: two instances (RESET_PC 0 and 0xFFFF_FFF8) against
// a registered program memory holding mem[i] = i*0x11.
module tb_instr_fetch;

  localparam int AW  = 32;
  localparam int MAW = 10;
  localparam int DW  = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic          fetch_en, redirect_valid, out_ready;
  logic [AW-1:0] redirect_pc;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0] rdata, out_instr;
  logic [AW-1:0] out_pc;
  logic          out_valid, misaligned;

  logic          fetch_en2;
  logic [MAW-1:0] mem_addr2;
  logic [DW-1:0] rdata2, out_instr2;
  logic [AW-1:0] out_pc2;
  logic          out_valid2, misaligned2;

  logic [31:0] mem [1024];
  exp_t        exp_q1[$];
  exp_t        exp_q2[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop1 = 0;
  int          n_pop2 = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_WIDTH(AW), .MEM_AW(MAW), .DATA_WIDTH(DW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .misaligned(misaligned)
  );

  instr_fetch #(.ADDR_WIDTH(AW), .MEM_AW(MAW), .DATA_WIDTH(DW), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .mem_addr(mem_addr2), .mem_rdata(rdata2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2),
    .out_pc(out_pc2), .misaligned(misaligned2)
  );

  initial for (int i = 0; i < 1024; i++) mem[i] = i * 32'h11;

  always @(posedge clk) begin
    rdata  <= mem[mem_addr];
    rdata2 <= mem[mem_addr2];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [9:0] wa;
    wa = pc[11:2];
    return 32'(wa) * 32'h11;
  endfunction

  task automatic push_seq1(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * k);
      exp_q1.push_back('{pc: pc, instr: word_at(pc)});
    end
  endtask

  task automatic push_seq2(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * k);
      exp_q2.push_back('{pc: pc, instr: word_at(pc)});
    end
  endtask

  // Monitors: every accepted transfer must match the next expected entry.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_pop1++;
      if (exp_q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut1_unexpected: got pc %h, expected no transfer", out_pc);
      end else begin
        exp_t e;
        e = exp_q1.pop_front();
        check("dut1_pc", out_pc, e.pc);
        check("dut1_instr", out_instr, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid2 === 1'b1) begin
      n_pop2++;
      if (exp_q2.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut2_unexpected: got pc %h, expected no transfer", out_pc2);
      end else begin
        exp_t e;
        e = exp_q2.pop_front();
        check("dut2_pc", out_pc2, e.pc);
        check("dut2_instr", out_instr2, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; fetch_en2 = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) tick();

    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_misaligned", misaligned, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_valid2", out_valid2, 0);
    check("rst_mem_addr2", mem_addr2, 10'h3FE);

    // Test 1: first fetch and back-to-back stream.
    push_seq1(32'h0, 32);
    rst = 1'b0; fetch_en = 1'b1;
    tick();
    check("lat_edge1_valid", out_valid, 0);
    tick();
    check("lat_edge2_valid", out_valid, 1);
    check("lat_edge2_pc", out_pc, 32'h0);
    check("lat_edge2_instr", out_instr, 32'h0);
    tick(); tick();
    check("stream_pc8", out_pc, 32'h8);
    check("stream_instr22", out_instr, 32'h22);

    // Test 2: decode stall for 5 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", out_pc, 32'h8);
      check("stall_valid", out_valid, 1);
      check("stall_mem_addr", mem_addr, 10'h4);
    end
    out_ready = 1'b1;
    repeat (4) tick();
    check("resume_pop_count", n_pop1, 6);

    // Test 3: redirect to 0x40 with the buffer full.
    out_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid_drop", out_valid, 0);
    check("redir_aligned_nopulse", misaligned, 0);
    exp_q1.delete();
    push_seq1(32'h40, 32);
    out_ready = 1'b1;
    tick();
    check("redir_edge1_valid", out_valid, 0);
    tick();
    check("redir_edge2_valid", out_valid, 1);
    check("redir_edge2_pc", out_pc, 32'h40);
    check("redir_edge2_instr", out_instr, 32'h110);

    // Test 4: misaligned redirect to 0x42 in a running stream.
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check("mis_pulse", misaligned, 1);
    check("mis_valid_drop", out_valid, 0);
    exp_q1.delete();
    push_seq1(32'h40, 32);
    tick();
    check("mis_pulse_end", misaligned, 0);
    tick();
    check("mis_resume_valid", out_valid, 1);
    check("mis_resume_pc", out_pc, 32'h40);

    // Test 5: PC wrap on the second instance; first instance drains.
    fetch_en = 1'b0;
    repeat (4) tick();
    check("drain_valid", out_valid, 0);
    push_seq2(32'hFFFF_FFF8, 16);
    fetch_en2 = 1'b1;
    tick();
    check("wrap_mem_addr_3ff", mem_addr2, 10'h3FF);
    tick();
    check("wrap_mem_addr_0", mem_addr2, 10'h000);
    check("wrap_first_pc", out_pc2, 32'hFFFF_FFF8);
    check("wrap_first_instr", out_instr2, 32'h43DE);
    repeat (8) tick();
    fetch_en2 = 1'b0;
    repeat (4) tick();
    check("wrap_drain_valid", out_valid2, 0);
    check("wrap_pop_count", n_pop2, 10);

    // Test 6: reset mid-stream with the buffer full.
    fetch_en = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mrst_valid", out_valid, 0);
    check("mrst_mem_addr", mem_addr, 10'h0);
    check("mrst_pc", out_pc, 32'h0);
    check("mrst_instr", out_instr, 32'h0);
    check("mrst_mem_addr2", mem_addr2, 10'h3FE);
    exp_q1.delete();
    push_seq1(32'h0, 16);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("mrst_edge1_valid", out_valid, 0);
    tick();
    check("mrst_edge2_valid", out_valid, 1);
    check("mrst_edge2_pc", out_pc, 32'h0);
    repeat (5) tick();
    check("mrst_tail_pc", out_pc, 32'h14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
